// File: rtl/softmax_row_loader.sv
// Gathers one streamed S5.10 score row into a 64-lane parallel register for the max finder.
// Lanes that no element reaches stay at the most-negative value, so short rows are harmless downstream.
module softmax_row_loader #(
    parameter int                DATA_W  = 16,
    parameter int                N_LANES = 64,
    parameter int                CNT_W   = 7,
    parameter logic [DATA_W-1:0] PAD_VAL = 16'h8000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [N_LANES*DATA_W-1:0]   row_data,
    output logic [CNT_W-1:0]            row_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;

    logic elem_accept;
    logic row_accept;
    logic row_done;

    assign elem_accept = in_valid & in_ready;
    assign row_accept  = row_valid & row_ready;
    assign row_done    = elem_accept & (in_last | (idx == CNT_W'(N_LANES - 1)));

    // in_ready and row_valid are registered so they are never high together;
    // the FILL/HOLD switch costs exactly one bubble cycle per row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            row_data  <= {N_LANES{PAD_VAL}};
            row_valid <= 1'b0;
            row_count <= '0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (elem_accept) begin
                        for (int k = 0; k < N_LANES; k++) begin
                            if (idx == CNT_W'(k)) begin
                                row_data[k*DATA_W +: DATA_W] <= in_data;
                            end
                        end
                    end
                    if (row_done) begin
                        row_count <= idx + 1'b1;
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        row_valid <= 1'b1;
                    end else begin
                        if (elem_accept) begin
                            idx <= idx + 1'b1;
                        end
                        in_ready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (row_accept) begin
                        row_data  <= {N_LANES{PAD_VAL}};
                        idx       <= '0;
                        row_count <= '0;
                        state     <= FILL;
                        in_ready  <= 1'b1;
                        row_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= FILL;
                    in_ready  <= 1'b0;
                    row_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_loader.sv
// Scoreboard bench for softmax_row_loader: each driven row pushes its expected image,
// which is popped and compared when the DUT hands the row downstream.
module tb_softmax_row_loader;

    localparam int DW = 16;
    localparam int NL = 64;
    localparam int CW = 7;
    localparam int RW = NL * DW;
    localparam logic [DW-1:0] PAD = 16'h8000;

    typedef struct {
        logic [RW-1:0] data;
        logic [CW-1:0] count;
        logic [DW-1:0] maxv;
    } row_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_data;
    logic [CW-1:0] row_count;

    int   checks;
    int   errors;
    row_t exp_q[$];

    softmax_row_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_count (row_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic row_t build_row(input logic [DW-1:0] elems[NL], input int n);
        row_t r;
        r.data  = {NL{PAD}};
        r.count = CW'(n);
        r.maxv  = PAD;
        for (int i = 0; i < n; i++) begin
            r.data[i*DW +: DW] = elems[i];
            if ($signed(elems[i]) > $signed(r.maxv)) r.maxv = elems[i];
        end
        return r;
    endfunction

    // Drives elements first..n-1, returning how many cycles the first one stalled.
    task automatic applyStimulus(input logic [DW-1:0] elems[NL], input int n, input bit use_last,
                                 input bit gap, input int first, input bit push, output int stall0);
        int stall;
        stall0 = 0;
        if (push) exp_q.push_back(build_row(elems, n));
        for (int i = first; i < n; i++) begin
            if (gap && i > first) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = elems[i];
            in_last  = use_last && (i == n - 1);
            stall    = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                stall++;
                if (stall > 200) begin
                    checkOutput("in_ready_timeout", RW'(stall), '0);
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $fatal(1, "[TB] stalled waiting for in_ready");
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            if (i == first) stall0 = stall;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (push) begin
            checkOutput("latency_row_valid", RW'(row_valid), RW'(1));
            checkOutput("latency_in_ready", RW'(in_ready), RW'(0));
        end
    endtask

    // Pops the scoreboard on every row handshake and checks the never-both-high rule.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ready_valid_exclusive", RW'(in_ready & row_valid), '0);
            if (row_valid && row_ready) begin
                logic [DW-1:0] mx;
                mx = PAD;
                for (int k = 0; k < NL; k++) begin
                    if ($signed(row_data[k*DW +: DW]) > $signed(mx)) mx = row_data[k*DW +: DW];
                end
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_row", RW'(1), RW'(0));
                end else begin
                    row_t e;
                    e = exp_q.pop_front();
                    checkOutput("row_data", row_data, e.data);
                    checkOutput("row_count", RW'(row_count), RW'(e.count));
                    checkOutput("row_max", RW'(mx), RW'(e.maxv));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] a[NL];
        logic [DW-1:0] b[NL];
        row_t          held;
        int            stall;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        row_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_row_valid", RW'(row_valid), '0);
        checkOutput("reset_in_ready", RW'(in_ready), '0);
        checkOutput("reset_row_count", RW'(row_count), '0);
        checkOutput("reset_row_data", row_data, {NL{PAD}});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready_low", RW'(in_ready), '0);
        @(posedge clk); #1;
        checkOutput("release_in_ready_high", RW'(in_ready), RW'(1));

        $display("[TB] full row");
        for (int k = 0; k < NL; k++) a[k] = DW'(k);
        applyStimulus(a, NL, 1'b0, 1'b0, 0, 1'b1, stall);

        $display("[TB] short row");
        a[0] = 16'hFC00; a[1] = 16'hF800; a[2] = 16'h0400; a[3] = 16'h0000; a[4] = 16'hFE00;
        applyStimulus(a, 5, 1'b1, 1'b0, 0, 1'b1, stall);

        $display("[TB] backpressure");
        repeat (2) @(posedge clk);
        #1;
        row_ready = 1'b0;
        for (int k = 0; k < NL; k++) a[k] = DW'(16'h0100 + k * 3);
        applyStimulus(a, NL, 1'b0, 1'b0, 0, 1'b1, stall);
        held = build_row(a, NL);
        b[0] = 16'h7FFF; b[1] = 16'h1234; b[2] = 16'hC000; b[3] = 16'h0001; b[4] = 16'h0002;
        in_valid = 1'b1;
        in_data  = b[0];
        in_last  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_row_data", row_data, held.data);
            checkOutput("hold_in_ready", RW'(in_ready), '0);
            checkOutput("hold_row_valid", RW'(row_valid), RW'(1));
        end
        @(posedge clk); #1;
        row_ready = 1'b1;
        exp_q.push_back(build_row(b, 5));
        @(negedge clk);
        checkOutput("accept_cycle_in_ready", RW'(in_ready), '0);
        @(negedge clk);
        checkOutput("after_accept_in_ready", RW'(in_ready), RW'(1));
        checkOutput("after_accept_row_valid", RW'(row_valid), '0);
        checkOutput("after_accept_padded", row_data, {NL{PAD}});
        @(posedge clk); #1;
        applyStimulus(b, 5, 1'b1, 1'b0, 1, 1'b0, stall);
        checkOutput("bp_second_row_valid", RW'(row_valid), RW'(1));

        $display("[TB] gapped input");
        for (int k = 0; k < NL; k++) a[k] = DW'(k);
        applyStimulus(a, NL, 1'b1, 1'b1, 0, 1'b1, stall);

        $display("[TB] back to back");
        for (int k = 0; k < 8; k++) a[k] = DW'(16'hFFF0 + k);
        applyStimulus(a, 8, 1'b1, 1'b0, 0, 1'b1, stall);
        b[0] = PAD; b[1] = 16'h0001;
        applyStimulus(b, 2, 1'b1, 1'b0, 0, 1'b1, stall);
        checkOutput("bubble_cycles", RW'(stall), RW'(1));

        $display("[TB] reset mid row");
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) a[k] = DW'(16'h2000 + k);
        applyStimulus(a, 30, 1'b0, 1'b0, 0, 1'b0, stall);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_row_valid", RW'(row_valid), '0);
        checkOutput("midreset_row_data", row_data, {NL{PAD}});
        checkOutput("midreset_in_ready", RW'(in_ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        a[0] = 16'h0A00; a[1] = 16'hF600; a[2] = 16'h0005;
        applyStimulus(a, 3, 1'b1, 1'b0, 0, 1'b1, stall);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", RW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
